// File: rtl/sad_pkg.sv
// Shared constants and types for the SAD load controller: frame bytes, FSM states, coordinate widths.
// Purely declarative; no logic lives here.
package sad_pkg;

   localparam logic [7:0] SYNC_BYTE    = 8'hA5;
   localparam logic [7:0] CMD_LOAD_TPL = 8'h01;
   localparam logic [7:0] CMD_LOAD_IMG = 8'h02;
   localparam logic [7:0] CMD_RUN      = 8'h03;

   localparam int X_W = 10;
   localparam int Y_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      LD_TPL,
      LD_IMG,
      START,
      WAIT
   } state_t;

   // States in which a silent byte stream counts toward the timeout.
   function automatic logic gapActive(input state_t s);
      return (s == CMD) || (s == LD_TPL) || (s == LD_IMG);
   endfunction

endpackage

// File: rtl/sad_load_controller_if.sv
// Byte-stream, RAM-write, SAD-core and result signals of the load controller.
// master = controller side, slave = surrounding board logic.
interface sad_load_controller_if #(
   parameter int TPL_AW = 8,
   parameter int IMG_AW = 19
);
   import sad_pkg::*;

   logic              rx_start;
   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              tpl_we;
   logic [TPL_AW-1:0] tpl_addr;
   logic              img_we;
   logic [IMG_AW-1:0] img_addr;
   logic [7:0]        wr_data;
   logic              sad_start;
   logic              sad_done;
   logic [X_W-1:0]    sad_x;
   logic [Y_W-1:0]    sad_y;
   logic              valid;
   logic [X_W-1:0]    x_out;
   logic [Y_W-1:0]    y_out;
   logic              busy;
   logic              error;

   modport master (
      input  rx_start, rx_ready, rx_data, sad_done, sad_x, sad_y,
      output tpl_we, tpl_addr, img_we, img_addr, wr_data, sad_start,
             valid, x_out, y_out, busy, error
   );

   modport slave (
      output rx_start, rx_ready, rx_data, sad_done, sad_x, sad_y,
      input  tpl_we, tpl_addr, img_we, img_addr, wr_data, sad_start,
             valid, x_out, y_out, busy, error
   );

endinterface

// File: rtl/sad_load_controller_uart_gap_timer.sv
// Loadable down-counter: reloads to LOAD_VAL while load is high, otherwise counts down;
// expire is high for the single cycle in which the count reaches its last tick.
module uart_gap_timer #(
   parameter int LOAD_VAL = 1000000
) (
   input  logic clock,
   input  logic notReset,
   input  logic load,
   output logic expire
);

   localparam int W = $clog2(LOAD_VAL + 1);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (!notReset) begin
         count <= W'(LOAD_VAL);
      end else if (load) begin
         count <= W'(LOAD_VAL);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = !load && (count == W'(1));

endmodule

// File: rtl/sad_load_controller.sv
// Framed-command sequencer: loads template/image RAMs from the UART byte stream, runs the SAD core,
// and latches its best-match result. Writes follow rx_ready by exactly one cycle; no byte is buffered.
module sad_load_controller
   import sad_pkg::*;
#(
   parameter int TPL_W   = 16,
   parameter int TPL_H   = 16,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int TPL_AW  = 8,
   parameter int IMG_AW  = 19,
   parameter int TIMEOUT = 1000000
) (
   input logic                   clock,
   input logic                   notReset,
   sad_load_controller_if.master bus
);

   localparam int CW = (TPL_AW > IMG_AW) ? TPL_AW : IMG_AW;
   localparam logic [CW-1:0] TPL_LAST = CW'(TPL_W * TPL_H - 1);
   localparam logic [CW-1:0] IMG_LAST = CW'(IMG_W * IMG_H - 1);

   state_t        state;
   logic          tplLoaded;
   logic          imgLoaded;
   logic          finalWr;
   logic [CW-1:0] pixCount;
   logic          gapLoad;
   logic          gapExpire;

   assign gapLoad  = !gapActive(state) || bus.rx_ready || bus.rx_start;
   assign bus.busy = (state == LD_TPL) || (state == LD_IMG) || (state == START) || (state == WAIT);

   uart_gap_timer #(
      .LOAD_VAL(TIMEOUT)
   ) gapTimer (
      .clock   (clock),
      .notReset(notReset),
      .load    (gapLoad),
      .expire  (gapExpire)
   );

   always_ff @(posedge clock) begin
      if (!notReset) begin
         state         <= IDLE;
         tplLoaded     <= 1'b0;
         imgLoaded     <= 1'b0;
         finalWr       <= 1'b0;
         pixCount      <= '0;
         bus.tpl_we    <= 1'b0;
         bus.tpl_addr  <= '0;
         bus.img_we    <= 1'b0;
         bus.img_addr  <= '0;
         bus.wr_data   <= '0;
         bus.sad_start <= 1'b0;
         bus.valid     <= 1'b0;
         bus.x_out     <= '0;
         bus.y_out     <= '0;
         bus.error     <= 1'b0;
      end else begin
         bus.tpl_we    <= 1'b0;
         bus.img_we    <= 1'b0;
         bus.sad_start <= 1'b0;
         bus.valid     <= 1'b0;
         bus.error     <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.rx_ready && bus.rx_data == SYNC_BYTE) state <= CMD;
            end

            CMD: begin
               if (gapExpire) begin
                  bus.error <= 1'b1;
                  state     <= IDLE;
               end else if (bus.rx_ready) begin
                  case (bus.rx_data)
                     CMD_LOAD_TPL: begin
                        state     <= LD_TPL;
                        tplLoaded <= 1'b0;
                        pixCount  <= '0;
                        finalWr   <= 1'b0;
                     end
                     CMD_LOAD_IMG: begin
                        state     <= LD_IMG;
                        imgLoaded <= 1'b0;
                        pixCount  <= '0;
                        finalWr   <= 1'b0;
                     end
                     CMD_RUN: begin
                        if (tplLoaded && imgLoaded) begin
                           state         <= START;
                           bus.sad_start <= 1'b1;
                        end else begin
                           bus.error <= 1'b1;
                           state     <= IDLE;
                        end
                     end
                     default: begin
                        bus.error <= 1'b1;
                        state     <= IDLE;
                     end
                  endcase
               end
            end

            LD_TPL, LD_IMG: begin
               // finalWr marks the cycle carrying the last write; bytes arriving then are dropped.
               if (finalWr) begin
                  finalWr <= 1'b0;
                  state   <= IDLE;
                  if (state == LD_TPL) tplLoaded <= 1'b1;
                  else                 imgLoaded <= 1'b1;
               end else if (gapExpire) begin
                  bus.error <= 1'b1;
                  state     <= IDLE;
               end else if (bus.rx_ready) begin
                  bus.wr_data <= bus.rx_data;
                  pixCount    <= pixCount + 1'b1;
                  if (state == LD_TPL) begin
                     bus.tpl_we   <= 1'b1;
                     bus.tpl_addr <= pixCount[TPL_AW-1:0];
                     finalWr      <= (pixCount == TPL_LAST);
                  end else begin
                     bus.img_we   <= 1'b1;
                     bus.img_addr <= pixCount[IMG_AW-1:0];
                     finalWr      <= (pixCount == IMG_LAST);
                  end
               end
            end

            START: state <= WAIT;

            WAIT: begin
               if (bus.sad_done) begin
                  bus.x_out <= bus.sad_x;
                  bus.y_out <= bus.sad_y;
                  bus.valid <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sad_load_controller.sv
// Directed bench for sad_load_controller with a reduced image and timeout so every path runs quickly.
module tb_sad_load_controller;

   localparam int TPL_W = 16, TPL_H = 16, IMG_W = 8, IMG_H = 4;
   localparam int TPL_AW = 8, IMG_AW = 5, TIMEOUT = 40;

   logic clock = 1'b0;
   logic notReset = 1'b0;

   sad_load_controller_if #(.TPL_AW(TPL_AW), .IMG_AW(IMG_AW)) bus ();

   sad_load_controller #(
      .TPL_W(TPL_W), .TPL_H(TPL_H), .IMG_W(IMG_W), .IMG_H(IMG_H),
      .TPL_AW(TPL_AW), .IMG_AW(IMG_AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock   (clock),
      .notReset(notReset),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] imgByte(input int i);
      return 8'(i * 3 + 7);
   endfunction

   // Output monitor: counts pulses and flags write-latency/data anomalies.
   int   tplWeCnt = 0, imgWeCnt = 0, startCnt = 0, validCnt = 0, errCnt = 0;
   int   latErr = 0, dataErr = 0, bothErr = 0;
   logic rdyPrev = 1'b0;

   always @(posedge clock) rdyPrev <= bus.rx_ready;

   always @(negedge clock) begin
      if (bus.tpl_we) begin
         tplWeCnt <= tplWeCnt + 1;
         if (bus.wr_data != bus.tpl_addr) dataErr <= dataErr + 1;
      end
      if (bus.img_we) begin
         imgWeCnt <= imgWeCnt + 1;
         if (bus.wr_data != imgByte(int'(bus.img_addr))) dataErr <= dataErr + 1;
      end
      if ((bus.tpl_we || bus.img_we) && !rdyPrev) latErr <= latErr + 1;
      if (bus.tpl_we && bus.img_we) bothErr <= bothErr + 1;
      if (bus.sad_start) startCnt <= startCnt + 1;
      if (bus.valid) validCnt <= validCnt + 1;
      if (bus.error) errCnt <= errCnt + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      bus.rx_ready = 1'b1;
      bus.rx_data  = b;
      cyc(1);
      bus.rx_ready = 1'b0;
      cyc(1);
   endtask

   task automatic loadTpl();
      sendByte(8'hA5);
      sendByte(8'h01);
      for (int i = 0; i < TPL_W * TPL_H; i++) sendByte(8'(i));
   endtask

   task automatic loadImg();
      sendByte(8'hA5);
      sendByte(8'h02);
      for (int i = 0; i < IMG_W * IMG_H; i++) sendByte(imgByte(i));
   endtask

   task automatic doneStrobe(input logic [9:0] x, input logic [8:0] y);
      bus.sad_done = 1'b1;
      bus.sad_x    = x;
      bus.sad_y    = y;
      cyc(1);
      bus.sad_done = 1'b0;
      bus.sad_x    = '0;
      bus.sad_y    = '0;
   endtask

   int t0, i0, s0, v0, e0;

   initial begin
      bus.rx_start = 1'b0;
      bus.rx_ready = 1'b0;
      bus.rx_data  = '0;
      bus.sad_done = 1'b0;
      bus.sad_x    = '0;
      bus.sad_y    = '0;

      // Power-on reset values.
      cyc(3);
      check("rst_busy", bus.busy, 0);
      check("rst_we", {bus.tpl_we, bus.img_we, bus.sad_start, bus.valid, bus.error}, 0);
      check("rst_xy", {bus.x_out, bus.y_out}, 0);
      notReset = 1'b1;
      cyc(1);

      // Template load 0x00..0xFF.
      sendByte(8'hA5);
      sendByte(8'h01);
      for (int i = 0; i < 256; i++) begin
         if (i == 255) check("tpl_busy_during", bus.busy, 1);
         sendByte(8'(i));
      end
      check("tpl_we_count", tplWeCnt, 256);
      check("tpl_last_addr", bus.tpl_addr, 255);
      check("tpl_busy_after", bus.busy, 0);

      // Reset held 3 cycles in the middle of an image load.
      sendByte(8'hA5);
      sendByte(8'h02);
      for (int i = 0; i < 10; i++) sendByte(imgByte(i));
      check("img_partial_addr", bus.img_addr, 9);
      check("img_busy_mid", bus.busy, 1);
      notReset = 1'b0;
      cyc(3);
      notReset = 1'b1;
      cyc(1);
      check("rstmid_busy", bus.busy, 0);
      check("rstmid_addr", {bus.tpl_addr, bus.img_addr, bus.wr_data}, 0);
      check("rstmid_pulses", {bus.tpl_we, bus.img_we, bus.sad_start, bus.valid, bus.error}, 0);

      // Stray bytes then RUN with flags cleared by reset.
      e0 = errCnt; s0 = startCnt; t0 = tplWeCnt; i0 = imgWeCnt;
      sendByte(8'h11);
      sendByte(8'h22);
      check("stray_no_err", errCnt, e0);
      sendByte(8'hA5);
      sendByte(8'h03);
      cyc(2);
      check("run_unloaded_err", errCnt, e0 + 1);
      check("run_unloaded_start", startCnt, s0);
      check("run_unloaded_wr", tplWeCnt + imgWeCnt, t0 + i0);

      // Full load, run, bytes during WAIT, completion.
      t0 = tplWeCnt; i0 = imgWeCnt;
      loadTpl();
      loadImg();
      check("reload_tpl_count", tplWeCnt, t0 + 256);
      check("img_count", imgWeCnt, i0 + IMG_W * IMG_H);
      check("img_last_addr", bus.img_addr, IMG_W * IMG_H - 1);
      s0 = startCnt; v0 = validCnt; e0 = errCnt;
      t0 = tplWeCnt; i0 = imgWeCnt;
      sendByte(8'hA5);
      sendByte(8'h03);
      check("run_start", startCnt, s0 + 1);
      check("run_busy", bus.busy, 1);
      sendByte(8'hA5);
      sendByte(8'h01);
      sendByte(8'h33);
      check("wait_no_wr", tplWeCnt + imgWeCnt, t0 + i0);
      check("wait_no_start", startCnt, s0 + 1);
      doneStrobe(10'd123, 9'd45);
      check("run_valid_now", bus.valid, 1);
      check("run_x", bus.x_out, 123);
      check("run_y", bus.y_out, 45);
      cyc(3);
      check("run_valid_once", validCnt, v0 + 1);
      check("run_xy_hold", {bus.x_out, bus.y_out}, {10'd123, 9'd45});
      check("run_idle_busy", bus.busy, 0);
      check("run_no_err", errCnt, e0);

      // Repeat RUN reuses the loaded data.
      sendByte(8'hA5);
      sendByte(8'h03);
      check("rerun_start", startCnt, s0 + 2);
      cyc(2);
      doneStrobe(10'd7, 9'd3);
      cyc(1);
      check("rerun_xy", {bus.x_out, bus.y_out}, {10'd7, 9'd3});
      check("rerun_valid", validCnt, v0 + 2);

      // sad_done outside WAIT is ignored.
      doneStrobe(10'd500, 9'd200);
      cyc(2);
      check("stray_done_valid", validCnt, v0 + 2);
      check("stray_done_xy", {bus.x_out, bus.y_out}, {10'd7, 9'd3});

      // Unknown command.
      e0 = errCnt; t0 = tplWeCnt; i0 = imgWeCnt;
      sendByte(8'hA5);
      sendByte(8'h7F);
      cyc(2);
      check("badcmd_err", errCnt, e0 + 1);
      check("badcmd_no_wr", tplWeCnt + imgWeCnt, t0 + i0);
      check("badcmd_busy", bus.busy, 0);

      // Timeout during a template load.
      e0 = errCnt; s0 = startCnt;
      sendByte(8'hA5);
      sendByte(8'h01);
      for (int i = 0; i < 10; i++) sendByte(8'(i));
      cyc(TIMEOUT - 6);
      check("to_not_early", errCnt, e0);
      check("to_busy_wait", bus.busy, 1);
      for (int i = 0; i < 12 && errCnt == e0; i++) cyc(1);
      cyc(2);
      check("to_err", errCnt, e0 + 1);
      check("to_idle", bus.busy, 0);
      sendByte(8'hA5);
      sendByte(8'h03);
      cyc(2);
      check("to_run_err", errCnt, e0 + 2);
      check("to_run_nostart", startCnt, s0);

      check("write_latency", latErr, 0);
      check("write_data", dataErr, 0);
      check("we_exclusive", bothErr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sad_load_controller.md
Name: sad_load_controller

Overview:
- Command sequencer between the UART byte receiver and the SAD matching core.
- Parses framed commands from the byte stream and loads template and search-image pixels into their RAMs with generated addresses.
- Starts the SAD core on command, waits for completion, and latches the best-match coordinates onto the board-level result outputs.

Parameters:
- TPL_W, 16, template width in pixels
- TPL_H, 16, template height in pixels
- IMG_W, 640, search image width in pixels
- IMG_H, 480, search image height in pixels
- TPL_AW, 8, template RAM address width (must hold TPL_W*TPL_H-1)
- IMG_AW, 19, image RAM address width (must hold IMG_W*IMG_H-1)
- TIMEOUT, 1000000, maximum clock cycles allowed between payload bytes

Ports:
- clock  in  1  system clock
- notReset  in  1  synchronous active-low reset
- rx_start  in  1  UART start-bit detect; ignored except to restart the timeout counter
- rx_ready  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tpl_we  out  1  template RAM write enable
- tpl_addr  out  TPL_AW  template RAM write address
- img_we  out  1  image RAM write enable
- img_addr  out  IMG_AW  image RAM write address
- wr_data  out  8  pixel data for either RAM
- sad_start  out  1  one-cycle start pulse to SAD core
- sad_done  in  1  one-cycle completion strobe from SAD core
- sad_x  in  10  best-match x from SAD core, valid with sad_done
- sad_y  in  9  best-match y from SAD core, valid with sad_done
- valid  out  1  one-cycle pulse: new result on x_out/y_out
- x_out  out  10  latched match x
- y_out  out  9  latched match y
- busy  out  1  high while loading or while the SAD core runs
- error  out  1  one-cycle pulse on protocol fault or timeout

Behaviour:
- Clock is `clock`. Reset is `notReset`: synchronous, active-low, sampled on the rising edge of `clock`.
- Reset values:
  - all outputs 0; addresses 0; x_out/y_out 0
  - tpl_loaded and img_loaded flags 0
  - state IDLE
- Frame format: sync byte 0xA5, then a command byte:
  - 0x01 LOAD_TPL: TPL_W*TPL_H payload bytes follow, raster order
  - 0x02 LOAD_IMG: IMG_W*IMG_H payload bytes follow, raster order
  - 0x03 RUN: no payload
- States:
  - IDLE: a byte equal to 0xA5 goes to CMD; any other byte is discarded silently.
  - CMD: on the next byte:
    - 0x01 goes to LD_TPL and clears tpl_loaded and the pixel counter.
    - 0x02 goes to LD_IMG and clears img_loaded and the pixel counter.
    - 0x03 goes to START if both loaded flags are set; otherwise error pulse and return to IDLE.
    - Any other value: error pulse, return to IDLE.
  - LD_TPL / LD_IMG:
    - Each rx_ready produces, in the next cycle, a one-cycle we with addr = counter and wr_data = byte; the counter then increments.
    - The cycle after the final write sets the matching loaded flag and returns to IDLE.
  - START: sad_start pulses for exactly one cycle, then WAIT.
  - WAIT:
    - Bytes are ignored; no byte is ever buffered.
    - On sad_done, latch sad_x/sad_y into x_out/y_out and pulse valid in the next cycle.
    - Return to IDLE. The loaded flags are kept, so repeated RUN reuses the loaded data.
- busy = 1 in LD_TPL, LD_IMG, START and WAIT.
- Write latency: exactly 1 cycle from rx_ready to we. tpl_we and img_we are never both high.
- Timeout:
  - In CMD, LD_TPL and LD_IMG, a gap counter counts cycles since the last rx_ready; rx_start also clears it.
  - When the counter reaches TIMEOUT: error pulse, go to IDLE, and the loaded flag of the aborted load stays 0.
  - The counter is idle in every other state. WAIT has no timeout.
- Simultaneous events:
  - A write cycle and a new rx_ready in the same cycle are both honoured; the pipeline is one deep, and rx_ready cannot recur faster than one byte time.
  - sad_done outside WAIT is ignored.
- Counter end value is compared against (count-1) at full width; no wrap past the final address.
- Reset during a load abandons it. RAM contents are unspecified and the flags are cleared.

Decomposition:
- Shared package sad_pkg:
  - SYNC_BYTE, CMD_LOAD_TPL, CMD_LOAD_IMG, CMD_RUN
  - state enum
  - coordinate widths 10/9
- One natural sub-module, uart_gap_timer: loadable down-counter with clear and expire outputs, reused for the timeout.

Test Plan:
- Reset held low 3 cycles mid-LD_IMG, then released -> all outputs 0, busy 0, a subsequent RUN gives an error pulse (flags cleared).
- A5 01 + 256 bytes 0x00..0xFF -> 256 tpl_we pulses, tpl_addr 0..255 with wr_data equal to addr, one cycle after each rx_ready; busy falls after the last write.
- Template loaded, then A5 02 + IMG_W*IMG_H bytes, then A5 03; model returns sad_done with x=123, y=45 -> exactly one sad_start, then valid for 1 cycle with x_out=123 and y_out=45 held afterwards.
- A5 03 with no image loaded -> error 1 cycle, no sad_start; stray bytes 0x11 0x22 before A5 are ignored.
- A5 01 then 10 bytes then silence for TIMEOUT cycles -> error pulse, state IDLE, a following RUN gives an error.
- A5 7F -> error pulse, no writes; extra bytes sent during WAIT -> no writes and no extra sad_start.
